// File: rtl/rr_grant_encoder.sv
// Registered round-robin arbiter and grant encoder.
// Collapses a request vector into one granted index plus its one-hot form,
// and holds that grant under a valid/ack handshake. A rotating priority
// pointer moves past each acknowledged requester so service stays fair.
module rr_grant_encoder #(
  parameter int NUM_INPUTS = 5,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_INPUTS-1:0] i_request,
  input  logic                  i_ack,
  output logic                  o_grant_valid,
  output logic [IDX_W-1:0]      o_grant_index,
  output logic [NUM_INPUTS-1:0] o_grant_onehot
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } search_t;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_INPUTS-1:0]   onehot_q, onehot_d;

  search_t                 idle_win;
  search_t                 ack_win;
  logic [IDX_W-1:0]        ack_ptr;
  logic [NUM_INPUTS-1:0]   req_shift;
  logic                    holder_req;

  // Scan start, start+1, ... modulo NUM_INPUTS; the first requester wins.
  function automatic search_t rr_search(input logic [NUM_INPUTS-1:0] req,
                                        input logic [IDX_W-1:0]      start);
    search_t               res;
    logic [NUM_INPUTS-1:0] rot;
    int                    k;
    res = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      k = int'(start) + i;
      if (k >= NUM_INPUTS) k = k - NUM_INPUTS;
      rot = req >> k;
      if (!res.hit && rot[0]) begin
        res.hit = 1'b1;
        res.idx = IDX_W'(k);
      end
    end
    return res;
  endfunction

  // Candidate winners: one from the current pointer (used from IDLE) and
  // one from the post-ack pointer (used for zero-bubble back-to-back grants).
  always_comb begin
    ack_ptr    = (idx_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : idx_q + IDX_W'(1);
    idle_win   = rr_search(i_request, ptr_q);
    ack_win    = rr_search(i_request, ack_ptr);
    req_shift  = i_request >> idx_q;
    holder_req = req_shift[0];
  end

  // Next-state logic: grant from IDLE, hold in GRANTED until ack or withdrawal.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = '0;

    case (state_q)
      IDLE: begin
        if (idle_win.hit) begin
          state_d = GRANTED;
          idx_d   = idle_win.idx;
        end
      end
      GRANTED: begin
        if (i_ack) begin
          // Ack wins over a simultaneous withdrawal; the acked requester
          // ranks last under the advanced pointer.
          ptr_d = ack_ptr;
          if (ack_win.hit) begin
            idx_d = ack_win.idx;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else if (!holder_req) begin
          // Withdrawal: drop the grant, keep the pointer, re-arbitrate from IDLE.
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (state_d == GRANTED) onehot_d = NUM_INPUTS'(1) << idx_d;
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign o_grant_valid  = (state_q == GRANTED);
  assign o_grant_index  = idx_q;
  assign o_grant_onehot = onehot_q;

endmodule
